// File: rtl/fl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fl_pkg
//  Description : Shared widths, constants, FSM state type and flag indices
//                for the binary32 post-add normaliser.
//  Revision    : 1.0 - initial release
// ============================================================================
package fl_pkg;

    localparam int EXP_W    = 8;
    localparam int MANT_W   = 23;
    localparam int EXP_BIAS = 127;
    localparam int EXP_MAX  = 255;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int FLAG_ZERO   = 0;
    localparam int FLAG_DENORM = 1;
    localparam int FLAG_INF    = 2;

endpackage : fl_pkg
`default_nettype wire

// File: rtl/fl_pack_32bit.sv
`default_nettype none
// ============================================================================
//  Module      : fl_pack_32bit
//  Description : Combinational packer. Assembles sign/exponent/fraction into
//                the IEEE-754 word and raises {inf, denorm, zero} flags.
//                Zero forces an all-zero word; inf forces exponent all-ones
//                with an empty fraction; denorm forces a zero exponent.
//  Revision    : 1.0 - initial release
// ============================================================================
module fl_pack_32bit #(
    parameter int EXP_W  = fl_pkg::EXP_W,
    parameter int MANT_W = fl_pkg::MANT_W
) (
    input  logic                    sign,
    input  logic [EXP_W-1:0]        exp,
    input  logic [MANT_W-1:0]       frac,
    input  logic                    sel_zero,
    input  logic                    sel_inf,
    input  logic                    sel_denorm,
    output logic [EXP_W+MANT_W:0]   result,
    output logic [2:0]              flags
);
    import fl_pkg::*;

    // Select the packed word and its flag bits by priority: zero, inf, denorm, plain
    always_comb begin
        result = {sign, exp, frac};
        flags  = 3'b000;
        if (sel_zero) begin
            result           = '0;
            flags[FLAG_ZERO] = 1'b1;
        end else if (sel_inf) begin
            result          = {sign, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
            flags[FLAG_INF] = 1'b1;
        end else if (sel_denorm) begin
            result             = {sign, {EXP_W{1'b0}}, frac};
            flags[FLAG_DENORM] = 1'b1;
        end
    end

endmodule : fl_pack_32bit
`default_nettype wire

// File: rtl/fl_normalizer_32bit.sv
`default_nettype none
// ============================================================================
//  Module      : fl_normalizer_32bit
//  Description : Post-add normalisation stage for single precision. Accepts
//                the adder's raw {sign, exp, carry+hidden+fraction} result,
//                fixes a carry with one right shift, removes cancellation
//                with one left shift per cycle, and packs binary32 output
//                behind valid/ready handshakes.
//                Build option FL_NORM_RNE_EN: round-to-nearest-even on the
//                carry right shift (otherwise the dropped bit is truncated).
//  Revision    : 1.0 - initial release
// ============================================================================
module fl_normalizer_32bit #(
    parameter int EXP_W  = fl_pkg::EXP_W,
    parameter int MANT_W = fl_pkg::MANT_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_sign,
    input  logic [EXP_W-1:0]        in_exp,
    input  logic [MANT_W+1:0]       in_mant,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [EXP_W+MANT_W:0]   out,
    output logic [2:0]              out_flags
);
    import fl_pkg::*;

    // Exponent is carried one bit wider so the carry/round increment cannot wrap
    localparam logic [EXP_W:0] EXP_ALL1 = {1'b0, {EXP_W{1'b1}}};
    localparam logic [EXP_W:0] EXP_ONE  = {{EXP_W{1'b0}}, 1'b1};
    localparam logic [EXP_W:0] EXP_TWO  = EXP_ONE + EXP_ONE;

    state_t                 state, state_nxt;
    logic                   sign_q;
    logic [EXP_W:0]         exp_q;
    logic [MANT_W+1:0]      mant_q;

    logic                   load, shift, finish;
    logic [EXP_W-1:0]       pk_exp;
    logic [MANT_W-1:0]      pk_frac;
    logic                   pk_zero, pk_inf, pk_denorm;
    logic [EXP_W+MANT_W:0]  pk_out;
    logic [2:0]             pk_flags;

    logic [MANT_W-1:0]      cy_frac;
    logic [EXP_W:0]         cy_exp;
    logic                   cy_inf;

`ifdef FL_NORM_RNE_EN
    // Shifted significand always has its hidden bit set; add the round bit on top
    logic                   round_up;
    logic [MANT_W+1:0]      rnd_sum;
    logic                   rnd_ovf;
    assign round_up = mant_q[0] & mant_q[1];
    assign rnd_sum  = {1'b0, 1'b1, mant_q[MANT_W:1]} + {{(MANT_W+1){1'b0}}, round_up};
    assign rnd_ovf  = rnd_sum[MANT_W+1];
    assign cy_frac  = rnd_ovf ? rnd_sum[MANT_W:1] : rnd_sum[MANT_W-1:0];
    assign cy_exp   = exp_q + (rnd_ovf ? EXP_TWO : EXP_ONE);
`else
    assign cy_frac  = mant_q[MANT_W:1];
    assign cy_exp   = exp_q + EXP_ONE;
`endif
    assign cy_inf   = (cy_exp >= EXP_ALL1);

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state and one normalisation decision per STEP cycle, in priority order
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        shift     = 1'b0;
        finish    = 1'b0;
        pk_exp    = exp_q[EXP_W-1:0];
        pk_frac   = mant_q[MANT_W-1:0];
        pk_zero   = 1'b0;
        pk_inf    = 1'b0;
        pk_denorm = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    load      = 1'b1;
                    state_nxt = STEP;
                end
            end
            STEP: begin
                if (exp_q == EXP_ALL1) begin
                    finish = 1'b1;
                end else if (mant_q == '0) begin
                    finish  = 1'b1;
                    pk_zero = 1'b1;
                end else if (mant_q[MANT_W+1]) begin
                    finish  = 1'b1;
                    pk_exp  = cy_exp[EXP_W-1:0];
                    pk_frac = cy_frac;
                    pk_inf  = cy_inf;
                end else if (mant_q[MANT_W]) begin
                    finish = 1'b1;
                end else if (exp_q == '0 || exp_q == EXP_ONE) begin
                    finish    = 1'b1;
                    pk_denorm = 1'b1;
                end else begin
                    shift = 1'b1;
                end
                if (finish) state_nxt = DONE;
            end
            DONE: begin
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Working registers: capture on accept, walk left one bit per shift cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_q <= 1'b0;
            exp_q  <= '0;
            mant_q <= '0;
        end else if (load) begin
            sign_q <= in_sign;
            exp_q  <= {1'b0, in_exp};
            mant_q <= in_mant;
        end else if (shift) begin
            mant_q <= {mant_q[MANT_W:0], 1'b0};
            exp_q  <= exp_q - EXP_ONE;
        end
    end

    // Result registers: written once when normalisation finishes, held through DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out       <= '0;
            out_flags <= 3'b000;
        end else if (finish) begin
            out       <= pk_out;
            out_flags <= pk_flags;
        end
    end

    fl_pack_32bit #(
        .EXP_W  (EXP_W),
        .MANT_W (MANT_W)
    ) u_pack (
        .sign       (sign_q),
        .exp        (pk_exp),
        .frac       (pk_frac),
        .sel_zero   (pk_zero),
        .sel_inf    (pk_inf),
        .sel_denorm (pk_denorm),
        .result     (pk_out),
        .flags      (pk_flags)
    );

endmodule : fl_normalizer_32bit
`default_nettype wire

// File: tb/tb_fl_normalizer_32bit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fl_normalizer_32bit
//  Description : Self-checking bench for fl_normalizer_32bit with an
//                arithmetic reference model, directed corner cases and
//                randomized traffic with random consumer back-pressure.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fl_normalizer_32bit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [24:0] in_mant;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out;
    logic [2:0]  out_flags;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int hold_cnt = 0;
    bit first  = 1'b1;

    logic [31:0] q_out[$];
    logic [2:0]  q_flg[$];
    int          q_due[$];

    fl_normalizer_32bit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_exp    (in_exp),
        .in_mant   (in_mant),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .out_flags (out_flags)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model: result from the value's numeric rules, k = cycles spent shifting
    function automatic void model(input logic s, input logic [7:0] e, input logic [24:0] m,
                                  output logic [31:0] o, output logic [2:0] f, output int k);
        longint mv;
        int     ev;
        int     p;
        int     need;
        logic [7:0] eo;
        k  = 0;
        f  = 3'b000;
        ev = int'(e);
        if (e == 8'hFF) begin
            o = {s, 8'hFF, m[22:0]};
        end else if (m == 25'd0) begin
            o = 32'h0;
            f = 3'b001;
        end else if (m[24]) begin
            mv = longint'(m) / 2;
            ev = ev + 1;
`ifdef FL_NORM_RNE_EN
            if (m[0] && m[1]) begin
                mv = mv + 1;
                if (mv >= 64'd16777216) begin
                    mv = mv / 2;
                    ev = ev + 1;
                end
            end
`endif
            if (ev >= 255) begin
                o = {s, 8'hFF, 23'h0};
                f = 3'b100;
            end else begin
                eo = 8'(ev);
                o  = {s, eo, mv[22:0]};
            end
        end else if (m[23]) begin
            o = {s, e, m[22:0]};
        end else if (e == 8'h00) begin
            o = {s, 8'h00, m[22:0]};
            f = 3'b010;
        end else begin
            p = 0;
            for (int i = 0; i < 24; i++) if (m[i]) p = i;
            need = 23 - p;
            if (need <= ev - 1) begin
                k  = need;
                mv = longint'(m) << need;
                eo = 8'(ev - need);
                o  = {s, eo, mv[22:0]};
            end else begin
                k  = ev - 1;
                mv = longint'(m) << k;
                o  = {s, 8'h00, mv[22:0]};
                f  = 3'b010;
            end
        end
    endfunction

    // Drive one transaction; in_valid is left high so callers may chain back-to-back
    task automatic send(input logic s, input logic [7:0] e, input logic [24:0] m);
        logic [31:0] eo;
        logic [2:0]  ef;
        int          k;
        int          n;
        in_sign  = s;
        in_exp   = e;
        in_mant  = m;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 64'(in_ready), 64'd1);
            in_valid = 1'b0;
            return;
        end
        model(s, e, m, eo, ef, k);
        @(posedge clk);
        #1;
        chk("single_outstanding", 64'(q_out.size()), 64'd0);
        q_out.push_back(eo);
        q_flg.push_back(ef);
        q_due.push_back(cyc + 1 + k);
        @(negedge clk);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q_out.size() > 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 64'(q_out.size()), 64'd0);
    endtask

    // Compare process: checks every output-valid cycle, latency, and drives out_ready
    initial begin
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (out_valid) begin
                    if (q_out.size() == 0) begin
                        chk("spurious_out_valid", 64'(out_valid), 64'd0);
                    end else begin
                        chk("out_word", 64'(out), 64'(q_out[0]));
                        chk("out_flags", 64'(out_flags), 64'(q_flg[0]));
                        if (first) begin
                            chk("latency", 64'(cyc), 64'(q_due[0]));
                            first = 1'b0;
                        end
                    end
                end else if (q_out.size() > 0 && first && cyc > q_due[0]) begin
                    chk("latency_late", 64'(cyc), 64'(q_due[0]));
                    first = 1'b0;
                end
                if (out_valid && hold_cnt > 0) begin
                    out_ready = 1'b0;
                    hold_cnt--;
                end else begin
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                if (out_valid && out_ready && q_out.size() > 0) begin
                    void'(q_out.pop_front());
                    void'(q_flg.pop_front());
                    void'(q_due.pop_front());
                    first = 1'b1;
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog_expired cycle=%0d", cyc);
        $fatal(1);
    end

    initial begin
        logic [31:0] mo;
        logic [2:0]  mf;
        int          mk;
        logic [7:0]  re;
        logic [24:0] rm;
        int          sh;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_sign  = 1'b0;
        in_exp   = 8'h0;
        in_mant  = 25'h0;

        // Pin the model with hand-computed values
        model(1'b0, 8'h80, 25'h0800000, mo, mf, mk);
        chk("model_norm", {mo, 29'(mk), mf}, {32'h40000000, 29'd0, 3'b000});
        model(1'b0, 8'h80, 25'h1800000, mo, mf, mk);
        chk("model_carry", {mo, mf}, {32'h40C00000, 3'b000});
        model(1'b0, 8'h80, 25'h1800003, mo, mf, mk);
`ifdef FL_NORM_RNE_EN
        chk("model_carry_rnd", 64'(mo), 64'h40C00002);
`else
        chk("model_carry_rnd", 64'(mo), 64'h40C00001);
`endif
        model(1'b0, 8'h85, 25'h0000001, mo, mf, mk);
        chk("model_deep", {mo, 29'(mk), mf}, {32'h37000000, 29'd23, 3'b000});
        model(1'b1, 8'h10, 25'h0, mo, mf, mk);
        chk("model_zero", {mo, mf}, {32'h0, 3'b001});
        model(1'b0, 8'hFE, 25'h1000000, mo, mf, mk);
        chk("model_ovf", {mo, mf}, {32'h7F800000, 3'b100});
        model(1'b0, 8'hFF, 25'h0400000, mo, mf, mk);
        chk("model_special", {mo, mf}, {32'h7FC00000, 3'b000});
        model(1'b0, 8'h03, 25'h0000100, mo, mf, mk);
        chk("model_denorm", {mo, 29'(mk), mf}, {32'h00000400, 29'd2, 3'b010});

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out", {out, 29'(out_flags)}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases through the DUT
        send(1'b0, 8'h80, 25'h0800000); in_valid = 1'b0; drain();
        send(1'b0, 8'h80, 25'h1800000); in_valid = 1'b0; drain();
        send(1'b0, 8'h80, 25'h1800003); in_valid = 1'b0; drain();
        hold_cnt = 5;
        send(1'b0, 8'h85, 25'h0000001); in_valid = 1'b0; drain();
        chk("hold_consumed", 64'(hold_cnt), 64'd0);
        send(1'b1, 8'h10, 25'h0000000); in_valid = 1'b0; drain();
        send(1'b0, 8'hFE, 25'h1000000); in_valid = 1'b0; drain();
        send(1'b0, 8'hFF, 25'h0400000); in_valid = 1'b0; drain();
        // in_valid stays high across the busy period into the next transaction
        send(1'b0, 8'h03, 25'h0000100);
        send(1'b1, 8'h40, 25'h0000F00); in_valid = 1'b0; drain();

        // Reset in the middle of a deep cancellation aborts it silently
        send(1'b0, 8'h85, 25'h0000001);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        chk("abort_out", 64'(out), 64'd0);
        q_out.delete();
        q_flg.delete();
        q_due.delete();
        first = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);

        // Randomized traffic with mixed exponent classes and cancellation depths
        for (int t = 0; t < 300; t++) begin
            case ($urandom_range(0, 9))
                0:       re = 8'h00;
                1:       re = 8'h01;
                2:       re = 8'hFE;
                3:       re = 8'hFF;
                4:       re = 8'(2 + $urandom_range(0, 24));
                default: re = 8'($urandom);
            endcase
            sh = $urandom_range(0, 25);
            rm = 25'($urandom & ((32'd1 << sh) - 32'd1));
            if ($urandom_range(0, 4) == 0) rm[24] = 1'b1;
            send(1'($urandom), re, rm);
            if ($urandom_range(0, 1) == 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
        end
        in_valid = 1'b0;
        drain();
        repeat (5) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_fl_normalizer_32bit
`default_nettype wire
